cmp_mask_pack: RTL and testbench
================================

CMP_MASK_PACK -- requirements
Module: cmp_mask_pack

Interface
REQ-001 SHALL have parameter MASK_WIDTH, default 32: maximum elements per vector and width of the packed mask.
REQ-002 SHALL have parameter VL_WIDTH, default $clog2(MASK_WIDTH)+1: width of the vector-length input.
REQ-003 SHALL have port module_clk_i  in  1  single block clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  in  1  one-cycle pulse that begins a mask collection; ignored unless IDLE.
REQ-006 SHALL have port vl_i  in  VL_WIDTH  element count for this collection, sampled on accepted start_i.
REQ-007 SHALL have port op_i  in  2  flag select, sampled on accepted start_i: 00=lt_le, 01=ge_gt, 10=~lt_le, 11=~ge_gt.
REQ-008 SHALL have port elem_valid_i  in  1  a comparator result is presented this cycle.
REQ-009 SHALL have port lt_le_i  in  1  comparator LT/LE flag for the current element.
REQ-010 SHALL have port ge_gt_i  in  1  comparator GE/GT flag for the current element.
REQ-011 SHALL have port elem_ready_o  out  1  block accepts a result this cycle.
REQ-012 SHALL have port cmp_en_o  out  1  comparator clock-gate enable.
REQ-013 SHALL have port mask_o  out  MASK_WIDTH  packed mask, bit i = result of element i.
REQ-014 SHALL have port mask_valid_o  out  1  mask_o is complete.
REQ-015 SHALL have port mask_ready_i  in  1  consumer accepts mask_o.
REQ-016 SHALL have port busy_o  out  1  block is not IDLE.

Function
REQ-017 SHALL implement states IDLE, COLLECT and DONE.
REQ-018 IDLE: on start_i with vl_i>0, SHALL clear the mask, clear the element index, latch op_i and vl_i, and enter COLLECT the next cycle.
REQ-019 IDLE: on start_i with vl_i=0, SHALL enter DONE directly with mask_o all zero.
REQ-020 Any vl_i greater than MASK_WIDTH SHALL be clamped to MASK_WIDTH.
REQ-021 elem_ready_o SHALL be 1 only in COLLECT; an element is accepted when elem_valid_i and elem_ready_o are both 1.
REQ-022 On acceptance, SHALL write the op-selected, optionally inverted flag into mask bit [index] and increment index by 1.
REQ-023 The cycle the element with index vl-1 is accepted, SHALL transition to DONE; mask_valid_o SHALL rise the following cycle (1-cycle latency after the last element).
REQ-024 Mask bits at positions >= vl SHALL read 0.
REQ-025 cmp_en_o SHALL equal 1 in COLLECT and 0 otherwise.
REQ-026 DONE: mask_valid_o=1 and mask_o SHALL hold stable until mask_ready_i=1; on that handshake SHALL return to IDLE the next cycle.
REQ-027 start_i in COLLECT or DONE SHALL be ignored with no state change.
REQ-028 elem_valid_i outside COLLECT SHALL be ignored.
REQ-029 busy_o SHALL be 1 in COLLECT and DONE and 0 in IDLE.

Reset
REQ-030 Asserting rst_ni low at any time, including mid-collection, SHALL immediately force IDLE, mask_o=0, index=0, mask_valid_o=0, elem_ready_o=0, cmp_en_o=0 and busy_o=0.
REQ-031 After rst_ni deasserts, the first start_i SHALL be honoured on the first rising edge.

Structure
REQ-032 The op_i encoding enum and the state enum SHALL reside in the shared ALU package.
REQ-033 Single module; flag selection and inversion SHALL be a small combinational function inside it; no sub-module.

Verification
REQ-034 vl=4, op=00, lt_le stream 1,0,1,1 back-to-back -> mask_o=0x0000000D, mask_valid_o one cycle after 4th accept.
REQ-035 vl=3, op=11, ge_gt stream 1,1,0 with elem_valid_i bubbles -> mask_o=0x00000004; cmp_en_o high throughout COLLECT only.
REQ-036 vl=0 start -> DONE with mask_o=0, zero elements accepted.
REQ-037 vl=40 (MASK_WIDTH=32), all flags 1, op=00 -> exactly 32 accepts, mask_o=0xFFFFFFFF.
REQ-038 DONE with mask_ready_i=0 for 5 cycles and start_i pulsed -> mask_o stable, start ignored; return to IDLE after ready.
REQ-039 rst_ni low after 2 of 8 elements -> all outputs 0 at once; new vl=2 collection afterward gives a correct mask with no stale bits.

Source files
------------

// File: rtl/cmp_mask_pack_pkg.sv
// Shared ALU package for the compare-mask packer.
// Holds the comparator flag-select encoding and the packer state encoding
// so that the datapath and any checker modules agree on both.
package cmp_mask_pack_pkg;

    // Flag select applied to every element of one collection.
    // Bit 1 inverts the selected flag, bit 0 picks GE/GT over LT/LE.
    typedef enum logic [1:0] {
        OP_LT_LE     = 2'b00,
        OP_GE_GT     = 2'b01,
        OP_NOT_LT_LE = 2'b10,
        OP_NOT_GE_GT = 2'b11
    } cmp_op_e;

    // Packer control states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

endpackage

// File: rtl/cmp_mask_pack.sv
// Compare-mask packer: collects one comparator flag per vector element and
// packs them into a MASK_WIDTH-bit mask, bit i holding element i's result.
//
// Ports:
//   module_clk_i  - block clock, all state on the rising edge
//   rst_ni        - asynchronous active-low reset
//   start_i       - begin a collection (honoured only when idle)
//   vl_i, op_i    - element count and flag select, sampled on accepted start
//   elem_valid_i  - comparator result presented (lt_le_i / ge_gt_i)
//   elem_ready_o  - block accepts a result this cycle
//   cmp_en_o      - comparator clock-gate enable (high while collecting)
//   mask_o        - packed mask; mask_valid_o flags it complete
//   mask_ready_i  - consumer takes the mask
//   busy_o        - block is not idle
module cmp_mask_pack
    import cmp_mask_pack_pkg::*;
#(
    parameter int MASK_WIDTH = 32,
    parameter int VL_WIDTH   = $clog2(MASK_WIDTH) + 1
) (
    input  logic                  module_clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [VL_WIDTH-1:0]   vl_i,
    input  logic [1:0]            op_i,
    input  logic                  elem_valid_i,
    input  logic                  lt_le_i,
    input  logic                  ge_gt_i,
    output logic                  elem_ready_o,
    output logic                  cmp_en_o,
    output logic [MASK_WIDTH-1:0] mask_o,
    output logic                  mask_valid_o,
    input  logic                  mask_ready_i,
    output logic                  busy_o
);

    // Pick the comparator flag named by op and invert it when requested.
    function automatic logic sel_flag(input cmp_op_e op, input logic lt, input logic ge);
        logic f;
        case (op)
            OP_LT_LE:     f = lt;
            OP_GE_GT:     f = ge;
            OP_NOT_LT_LE: f = ~lt;
            OP_NOT_GE_GT: f = ~ge;
            default:      f = 1'b0;
        endcase
        return f;
    endfunction

    state_e                state_r, state_s;
    cmp_op_e               op_r, op_s;
    logic [VL_WIDTH-1:0]   vl_r, vl_s;
    logic [VL_WIDTH-1:0]   idx_r, idx_s;
    logic [MASK_WIDTH-1:0] mask_r, mask_s;
    logic [VL_WIDTH-1:0]   vl_clamp_s;
    logic                  flag_s;
    logic                  elem_ready_r;
    logic                  cmp_en_r;
    logic                  mask_valid_r;
    logic                  busy_r;

    // Clamp the requested length so the index never walks past the mask.
    always_comb begin
        vl_clamp_s = vl_i;
        if (32'(vl_i) > 32'(MASK_WIDTH)) begin
            vl_clamp_s = VL_WIDTH'(MASK_WIDTH);
        end else begin
            vl_clamp_s = vl_i;
        end
    end

    // Next-state, index, mask and latched-parameter logic.
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        vl_s    = vl_r;
        idx_s   = idx_r;
        mask_s  = mask_r;
        flag_s  = sel_flag(op_r, lt_le_i, ge_gt_i);
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    // Mask is cleared up front, so bits beyond vl stay zero
                    // and each accept only ever sets its own bit.
                    mask_s = {MASK_WIDTH{1'b0}};
                    idx_s  = {VL_WIDTH{1'b0}};
                    op_s   = cmp_op_e'(op_i);
                    vl_s   = vl_clamp_s;
                    if (vl_clamp_s == {VL_WIDTH{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                // elem_ready is high throughout COLLECT, so valid alone accepts.
                if (elem_valid_i) begin
                    mask_s = mask_r | (MASK_WIDTH'(flag_s) << idx_r);
                    idx_s  = idx_r + {{(VL_WIDTH-1){1'b0}}, 1'b1};
                    if (idx_s == vl_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_DONE: begin
                if (mask_ready_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output-flag registers; flags are decoded from the
    // next state so they line up exactly with the state they describe.
    always_ff @(posedge module_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_LT_LE;
            vl_r         <= {VL_WIDTH{1'b0}};
            idx_r        <= {VL_WIDTH{1'b0}};
            mask_r       <= {MASK_WIDTH{1'b0}};
            elem_ready_r <= 1'b0;
            cmp_en_r     <= 1'b0;
            mask_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            op_r         <= op_s;
            vl_r         <= vl_s;
            idx_r        <= idx_s;
            mask_r       <= mask_s;
            elem_ready_r <= (state_s == ST_COLLECT);
            cmp_en_r     <= (state_s == ST_COLLECT);
            mask_valid_r <= (state_s == ST_DONE);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign elem_ready_o = elem_ready_r;
    assign cmp_en_o     = cmp_en_r;
    assign mask_o       = mask_r;
    assign mask_valid_o = mask_valid_r;
    assign busy_o       = busy_r;

endmodule

// File: tb/tb_cmp_mask_pack.sv
// Scoreboard bench for cmp_mask_pack: the driver pushes the expected mask and
// element count per collection; a negedge monitor pops and compares on each
// mask handshake, counts accepted elements and checks mask stability.
module tb_cmp_mask_pack;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [5:0]  vl_i;
    logic [1:0]  op_i;
    logic        elem_valid_i;
    logic        lt_le_i;
    logic        ge_gt_i;
    logic        elem_ready_o;
    logic        cmp_en_o;
    logic [31:0] mask_o;
    logic        mask_valid_o;
    logic        mask_ready_i;
    logic        busy_o;

    typedef struct {
        logic [31:0] mask;
        int          n;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    cmp_mask_pack #(.MASK_WIDTH(32), .VL_WIDTH(6)) dut (
        .module_clk_i (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .vl_i         (vl_i),
        .op_i         (op_i),
        .elem_valid_i (elem_valid_i),
        .lt_le_i      (lt_le_i),
        .ge_gt_i      (ge_gt_i),
        .elem_ready_o (elem_ready_o),
        .cmp_en_o     (cmp_en_o),
        .mask_o       (mask_o),
        .mask_valid_o (mask_valid_o),
        .mask_ready_i (mask_ready_i),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: accept counting, mask stability, scoreboard comparison.
    initial begin
        int          acc;
        logic        prev_valid;
        logic [31:0] prev_mask;
        exp_t        e;
        acc = 0;
        prev_valid = 1'b0;
        prev_mask = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                acc = 0;
                prev_valid = 1'b0;
            end else begin
                if (elem_valid_i && elem_ready_o) acc++;
                if (prev_valid && mask_valid_o) chk("mask_stable", 64'(mask_o), 64'(prev_mask));
                prev_valid = mask_valid_o;
                prev_mask  = mask_o;
                if (mask_valid_o && mask_ready_i) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_mask", 64'(1), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        chk("mask", 64'(mask_o), 64'(e.mask));
                        chk("accepts", 64'(acc), 64'(e.n));
                    end
                    acc = 0;
                end
            end
        end
    end

    // One full collection: start, feed elements (with bubbles), hold in DONE
    // while pulsing start and junk elements, then acknowledge.
    task automatic run_txn(input logic [5:0] vl, input logic [1:0] op,
                           input logic [63:0] lt, input logic [63:0] ge,
                           input int bub, input int hold);
        int          eff;
        int          i;
        int          guard;
        logic [31:0] em;
        exp_t        e;
        eff = (vl > 6'd32) ? 32 : int'(vl);
        em = 32'd0;
        for (int k = 0; k < eff; k++) em[k] = op[1] ^ (op[0] ? ge[k] : lt[k]);
        e.mask = em;
        e.n = eff;
        sb_q.push_back(e);

        @(posedge clk); #1;
        start_i = 1'b1; vl_i = vl; op_i = op; elem_valid_i = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b0; vl_i = 6'($urandom_range(0, 63)); op_i = 2'($urandom);
        chk("busy_after_start", 64'(busy_o), 64'(1));

        i = 0;
        guard = 0;
        while (i < eff && guard < 2000) begin
            guard++;
            chk("collect_flags", 64'({elem_ready_o, cmp_en_o, mask_valid_o}), 64'(3'b110));
            if ($urandom_range(0, 99) < bub) begin
                elem_valid_i = 1'b0;
                lt_le_i = 1'($urandom);
                ge_gt_i = 1'($urandom);
            end else begin
                elem_valid_i = 1'b1;
                lt_le_i = lt[i];
                ge_gt_i = ge[i];
            end
            @(posedge clk);
            if (elem_valid_i) i++;
            #1;
        end
        if (i < eff) chk("collect_timeout", 64'(i), 64'(eff));

        // Junk elements in DONE must be ignored.
        elem_valid_i = 1'b1;
        lt_le_i = 1'($urandom);
        ge_gt_i = 1'($urandom);
        chk("done_flags", 64'({elem_ready_o, cmp_en_o, mask_valid_o, busy_o}), 64'(4'b0011));

        for (int h = 0; h < hold; h++) begin
            mask_ready_i = 1'b0;
            start_i = 1'b1;
            vl_i = 6'($urandom_range(1, 63));
            @(posedge clk); #1;
            chk("hold_flags", 64'({mask_valid_o, busy_o, elem_ready_o}), 64'(3'b110));
        end
        start_i = 1'b0;
        mask_ready_i = 1'b1;
        @(posedge clk); #1;
        mask_ready_i = 1'b0;
        elem_valid_i = 1'b0;
        chk("idle_after_ack", 64'({busy_o, mask_valid_o, elem_ready_o, cmp_en_o}), 64'(4'b0000));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0; vl_i = 6'd0; op_i = 2'd0;
        elem_valid_i = 1'b0; lt_le_i = 1'b0; ge_gt_i = 1'b0;
        mask_ready_i = 1'b0;
        #2;
        chk("reset_state", 64'({mask_o, mask_valid_o, elem_ready_o, cmp_en_o, busy_o}), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;

        // vl=4, op=00, lt stream 1,0,1,1 back-to-back.
        run_txn(6'd4, 2'b00, 64'hD, 64'h0, 0, 0);
        // vl=3, op=11, ge stream 1,1,0 with bubbles.
        run_txn(6'd3, 2'b11, 64'h0, 64'h3, 40, 1);
        // vl=0: straight to DONE, nothing accepted.
        run_txn(6'd0, 2'b01, 64'h0, 64'h0, 0, 0);
        // vl=40 clamps to 32, all flags set.
        run_txn(6'd40, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 0);
        // Hold DONE for 5 cycles with start pulsing.
        run_txn(6'd5, 2'b10, 64'h0A, 64'h0, 0, 5);
        // Exactly MASK_WIDTH elements.
        run_txn(6'd32, 2'b01, 64'h0, 64'h8000_0001_5A5A_3C3C, 20, 2);

        // Reset after 2 of 8 elements.
        @(posedge clk); #1;
        start_i = 1'b1; vl_i = 6'd8; op_i = 2'b00;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            elem_valid_i = 1'b1; lt_le_i = 1'b1; ge_gt_i = 1'b0;
            @(posedge clk); #1;
        end
        elem_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_collect", 64'({mask_o, mask_valid_o, elem_ready_o, cmp_en_o, busy_o}), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_ni = 1'b1;
        run_txn(6'd2, 2'b00, 64'h2, 64'h0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            run_txn(6'($urandom_range(0, 63)), 2'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 50), $urandom_range(0, 4));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
